// File: rtl/shift_seq_arbiter_if.sv
// rtl/shift_seq_arbiter_if.sv - request/response bundle between two requesters and the shift sequencer
interface shift_seq_arbiter_if #(
  parameter int N = 8
) ();
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_data;
  logic [1:0]     req_dir;
  logic [5:0]     req_amt;
  logic [1:0]     req_fill;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [N-1:0]   rsp_data;

  modport master (
    output req_valid, req_data, req_dir, req_amt, req_fill, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_dir, req_amt, req_fill, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_seq_arbiter.sv
// rtl/shift_seq_arbiter.sv - round-robin front end that loads and steps an external shifter per request
module shift_seq_arbiter #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                clr,
  shift_seq_arbiter_if.slave  bus,
  output logic                busy,
  output logic                sh_clr_n,
  output logic [1:0]          sh_ctrl,
  output logic [N-1:0]        sh_reg_in,
  output logic                sh_ls,
  output logic                sh_rs,
  output logic [2:0]          sh_num_shift,
  input  logic [N-1:0]        sh_reg_out
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  state_t         state_q, state_d;
  logic           rr_last_q, rr_last_d;
  logic [N-1:0]   op_data_q, op_data_d;
  logic           op_dir_q, op_dir_d;
  logic [2:0]     op_amt_q, op_amt_d;
  logic           op_fill_q, op_fill_d;
  logic           op_id_q, op_id_d;
  logic [2:0]     cnt_q, cnt_d;

  logic           gnt_any;
  logic           gnt_id;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_any = |bus.req_valid;
    case (bus.req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~rr_last_q;
      default: gnt_id = 1'b0;
    endcase
  end

  assign sh_clr_n     = ~clr;
  assign sh_num_shift = 3'd1;

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    op_data_d     = op_data_q;
    op_dir_d      = op_dir_q;
    op_amt_d      = op_amt_q;
    op_fill_d     = op_fill_q;
    op_id_d       = op_id_q;
    cnt_d         = cnt_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = 1'b0;
    bus.rsp_data  = '0;
    busy          = 1'b1;
    sh_ctrl       = 2'b00;
    sh_reg_in     = '0;
    sh_ls         = 1'b0;
    sh_rs         = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (gnt_any) begin
          bus.req_ready = (2'b01 << gnt_id) & {2{~clr}};
          op_data_d     = gnt_id ? bus.req_data[2*N-1:N] : bus.req_data[N-1:0];
          op_dir_d      = bus.req_dir[gnt_id];
          op_amt_d      = gnt_id ? bus.req_amt[5:3] : bus.req_amt[2:0];
          op_fill_d     = bus.req_fill[gnt_id];
          op_id_d       = gnt_id;
          rr_last_d     = gnt_id;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        sh_ctrl   = 2'b01;
        sh_reg_in = op_data_q;
        cnt_d     = op_amt_q;
        state_d   = (op_amt_q != 3'd0) ? SHIFT : RESP;
      end
      SHIFT: begin
        sh_ctrl = {1'b1, op_dir_q};
        sh_ls   = ~op_dir_q & op_fill_q;
        sh_rs   = op_dir_q & op_fill_q;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = op_id_q;
        bus.rsp_data  = sh_reg_out;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      op_data_q <= '0;
      op_dir_q  <= 1'b0;
      op_amt_q  <= 3'd0;
      op_fill_q <= 1'b0;
      op_id_q   <= 1'b0;
      cnt_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      op_data_q <= op_data_d;
      op_dir_q  <= op_dir_d;
      op_amt_q  <= op_amt_d;
      op_fill_q <= op_fill_d;
      op_id_q   <= op_id_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// tb/tb_shift_seq_arbiter.sv - bench for shift_seq_arbiter with a stand-in shifter and a transaction-level model
module tb_shift_seq_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  shift_seq_arbiter_if #(.N(N)) bus ();

  logic         busy, sh_clr_n, sh_ls, sh_rs;
  logic [1:0]   sh_ctrl;
  logic [N-1:0] sh_reg_in, sh_reg_out;
  logic [2:0]   sh_num_shift;

  shift_seq_arbiter #(.N(N)) dut (
    .clk(clk), .clr(clr), .bus(bus.slave), .busy(busy), .sh_clr_n(sh_clr_n),
    .sh_ctrl(sh_ctrl), .sh_reg_in(sh_reg_in), .sh_ls(sh_ls), .sh_rs(sh_rs),
    .sh_num_shift(sh_num_shift), .sh_reg_out(sh_reg_out)
  );

  // Stand-in for the external shifter (set tied inactive, one position per step).
  logic [N-1:0] sh_q;
  assign sh_reg_out = sh_q;
  always @(posedge clk) begin
    if (!sh_clr_n) sh_q <= '0;
    else case (sh_ctrl)
      2'b01:   sh_q <= sh_reg_in;
      2'b10:   sh_q <= {sh_q[N-2:0], sh_ls};
      2'b11:   sh_q <= {sh_rs, sh_q[N-1:1]};
      default: sh_q <= sh_q;
    endcase
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] shift_ref(input logic [7:0] d, input bit dir, input int k, input bit f);
    int v, fm;
    v  = d;
    fm = f ? ((1 << k) - 1) : 0;
    if (!dir) return 8'(((v << k) | fm) & 255);
    else      return 8'(((v >> k) | (fm << (8 - k))) & 255);
  endfunction

  // Transaction-level model: one op in flight, phases derived from cycles since acceptance.
  bit         m_busy = 0;
  int         m_rr   = 1;
  int         m_acc  = 0;
  bit         m_id, m_dir, m_fill;
  int         m_amt;
  logic [7:0] m_data, m_res;

  always @(negedge clk) begin : cmp_blk
    int d;
    bit g;
    logic [1:0] exp_rdy;
    chk("sh_clr_n", sh_clr_n, !clr);
    chk("num_shift", sh_num_shift, 1);
    if (clr) begin
      chk("req_ready_in_reset", bus.req_ready, 0);
      m_busy = 0;
      m_rr   = 1;
    end else if (!m_busy) begin
      case (bus.req_valid)
        2'b01:   g = 0;
        2'b10:   g = 1;
        default: g = (m_rr == 0);
      endcase
      exp_rdy = (bus.req_valid == 2'b00) ? 2'b00 : (2'b01 << g);
      chk("idle_req_ready", bus.req_ready, exp_rdy);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
      chk("idle_sh_ctrl", sh_ctrl, 0);
      chk("idle_ls_rs", {sh_ls, sh_rs}, 0);
      if (bus.req_valid != 2'b00) begin
        m_id   = g;
        m_data = g ? bus.req_data[15:8] : bus.req_data[7:0];
        m_amt  = g ? int'(bus.req_amt[5:3]) : int'(bus.req_amt[2:0]);
        m_dir  = bus.req_dir[g];
        m_fill = bus.req_fill[g];
        m_res  = shift_ref(m_data, m_dir, m_amt, m_fill);
        m_busy = 1;
        m_acc  = cyc;
        m_rr   = g;
      end
    end else begin
      d = cyc - m_acc;
      chk("busy_req_ready", bus.req_ready, 0);
      chk("busy_busy", busy, 1);
      if (d == 1) begin
        chk("load_ctrl", sh_ctrl, 2'b01);
        chk("load_reg_in", sh_reg_in, m_data);
        chk("load_ls_rs", {sh_ls, sh_rs}, 0);
        chk("load_rsp_valid", bus.rsp_valid, 0);
      end else if (d <= 1 + m_amt) begin
        chk("shift_ctrl", sh_ctrl, {1'b1, m_dir});
        chk("shift_ls", sh_ls, !m_dir && m_fill);
        chk("shift_rs", sh_rs, m_dir && m_fill);
        chk("shift_rsp_valid", bus.rsp_valid, 0);
      end else begin
        chk("resp_ctrl", sh_ctrl, 0);
        chk("resp_ls_rs", {sh_ls, sh_rs}, 0);
        chk("resp_valid", bus.rsp_valid, 1);
        chk("resp_id", bus.rsp_id, m_id);
        chk("resp_data", bus.rsp_data, m_res);
        if (bus.rsp_ready) m_busy = 0;
      end
    end
  end

  int rsp_q[$];
  always @(negedge clk) begin
    if (!clr && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(int'(bus.rsp_id));
  end

  task automatic do_req(input bit id, input logic [7:0] data, input bit dir, input logic [2:0] amt,
                        input bit fill, input int exp_lat, input logic [7:0] exp_data, input int hold);
    int t0;
    bit seen;
    @(posedge clk); #1;
    bus.req_valid = 2'b01 << id;
    bus.req_data  = id ? {data, 8'h00} : {8'h00, data};
    bus.req_dir   = id ? {dir, 1'b0} : {1'b0, dir};
    bus.req_amt   = id ? {amt, 3'b000} : {3'b000, amt};
    bus.req_fill  = id ? {fill, 1'b0} : {1'b0, fill};
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("dir_accept", bus.req_ready, 2'b01 << id);
    t0 = cyc;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("dir_rsp_seen", seen, 1);
    if (seen) begin
      chk("dir_latency", cyc - t0, exp_lat);
      chk("dir_rsp_id", bus.rsp_id, id);
      chk("dir_rsp_data", bus.rsp_data, exp_data);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("hold_data", bus.rsp_data, exp_data);
        chk("hold_ctrl", sh_ctrl, 0);
        chk("hold_req_ready", bus.req_ready, 0);
        chk("hold_busy", busy, 1);
      end
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    bus.req_valid = 2'b00; bus.req_data = '0; bus.req_dir = 2'b00;
    bus.req_amt = 6'd0; bus.req_fill = 2'b00; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_sh_ctrl", sh_ctrl, 0);
    chk("reset_shifter", sh_reg_out, 8'h00);

    do_req(1'b0, 8'hB5, 1'b0, 3'd3, 1'b0, 5, 8'hA8, 0);
    do_req(1'b1, 8'h0F, 1'b1, 3'd2, 1'b1, 4, 8'hC3, 0);
    do_req(1'b0, 8'h5A, 1'b0, 3'd0, 1'b0, 2, 8'h5A, 0);
    do_req(1'b1, 8'h3C, 1'b0, 3'd4, 1'b1, 6, 8'hCF, 4);

    // Both requesters valid straight out of reset.
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    rsp_q.delete();
    bus.req_valid = 2'b11; bus.req_data = {8'h81, 8'h7E}; bus.req_dir = 2'b01;
    bus.req_amt = {3'd2, 3'd1}; bus.req_fill = 2'b10; bus.rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.req_valid = 2'b00;
    repeat (10) @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("rr_count", rsp_q.size() >= 3, 1);
    if (rsp_q.size() >= 3) begin
      chk("rr_first", rsp_q[0], 0);
      chk("rr_second", rsp_q[1], 1);
      chk("rr_third", rsp_q[2], 0);
    end

    // Reset during the second shift step of an amt=5 op.
    @(posedge clk); #1;
    bus.req_valid = 2'b01; bus.req_data = {8'h00, 8'hFF}; bus.req_dir = 2'b00;
    bus.req_amt = 6'd5; bus.req_fill = 2'b01;
    @(negedge clk);
    chk("abort_accept", bus.req_ready, 2'b01);
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_shifter", sh_reg_out, 8'h00);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_data  = 16'($urandom);
      bus.req_dir   = 2'($urandom_range(0, 3));
      bus.req_amt   = 6'($urandom_range(0, 63));
      bus.req_fill  = 2'($urandom_range(0, 3));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      clr           = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk); #1;
    clr = 1'b0; bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
